// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the two-producer FIFO write-port arbiter.
// Holds the state encoding and the one-hot grant constants.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT0     = 2'b01;
  localparam logic [1:0] GRANT1     = 2'b10;

endpackage

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port between two producers.
// A grant is held for up to MAX_BURST accepted beats or until the owner drops valid.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_req0_valid,
  input  logic [DATA_WIDTH-1:0] i_req0_data,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic [DATA_WIDTH-1:0] i_req1_data,
  output logic                  o_req1_ready,
  input  logic                  i_fifo_full,
  output logic                  o_fifo_wren,
  output logic [DATA_WIDTH-1:0] o_fifo_wdata,
  output logic [1:0]            o_grant
);

  localparam int                CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  logic             r_rr_ptr;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             w_own_valid;
  logic             w_accept;
  logic             w_release;

  // Handshake: a beat transfers in any cycle where valid and ready are both high;
  // ready depends only on state and i_fifo_full, never on valid.
  always_comb begin
    w_own_valid  = 1'b0;
    o_fifo_wdata = '0;
    o_grant      = GRANT_NONE;
    case (r_state)
      GNT0: begin
        w_own_valid  = i_req0_valid;
        o_fifo_wdata = i_req0_data;
        o_grant      = GRANT0;
      end
      GNT1: begin
        w_own_valid  = i_req1_valid;
        o_fifo_wdata = i_req1_data;
        o_grant      = GRANT1;
      end
      default: ;
    endcase

    o_req0_ready = (r_state == GNT0) && !i_fifo_full;
    o_req1_ready = (r_state == GNT1) && !i_fifo_full;
    w_accept     = (o_req0_ready && i_req0_valid) || (o_req1_ready && i_req1_valid);
    o_fifo_wren  = w_accept;
    // Release ignores full: a stalled owner keeps the port unless it drops valid.
    w_release    = (r_state != IDLE) &&
                   (!w_own_valid || (w_accept && (r_beat_cnt == LAST_BEAT)));

    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_req0_valid && i_req1_valid) w_next_state = r_rr_ptr ? GNT1 : GNT0;
        else if (i_req0_valid)            w_next_state = GNT0;
        else if (i_req1_valid)            w_next_state = GNT1;
      end
      GNT0: begin
        if (w_release) begin
          if (i_req1_valid)      w_next_state = GNT1;
          else if (i_req0_valid) w_next_state = GNT0;
          else                   w_next_state = IDLE;
        end
      end
      GNT1: begin
        if (w_release) begin
          if (i_req0_valid)      w_next_state = GNT0;
          else if (i_req1_valid) w_next_state = GNT1;
          else                   w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_release) begin
        r_rr_ptr   <= (r_state == GNT0);
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

endmodule
